// File: rtl/pause_dim_ctrl_pkg.sv
// Shared types and default constants for the pause arbitration / screen-dim block.
package pause_pkg;

  // Fade sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FADE = 2'd2,
    ST_HOLD = 2'd3
  } fade_state_t;

  // 10 s of user pause at 24.576 MHz before the fade begins.
  localparam logic [31:0] DEF_DIM_DELAY  = 32'd245_760_000;
  // 100 ms between fade steps.
  localparam logic [23:0] DEF_FADE_TICKS = 24'd2_457_600;
  // Level 4 scales every channel by 4/8, i.e. half brightness.
  localparam logic [2:0]  DEF_MAX_LEVEL  = 3'd4;

  // 12-bit pixel, packed as {b,g,r} with 4 bits per channel.
  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb12_t;

endpackage

// File: rtl/pause_dim_ctrl_if.sv
// Video stream bundle: pixel colour plus blanking and sync timing.
interface pause_dim_ctrl_if;
  import pause_pkg::*;

  rgb12_t rgb;
  logic   hblank;
  logic   vblank;
  logic   hs;
  logic   vs;

  // Side that produces the stream.
  modport master (
    output rgb,
    output hblank,
    output vblank,
    output hs,
    output vs
  );

  // Side that consumes the stream.
  modport slave (
    input rgb,
    input hblank,
    input vblank,
    input hs,
    input vs
  );

endinterface

// File: rtl/pause_dim_ctrl_rgb_scale.sv
// Combinational single-channel dimmer: c' = (c * (8 - level)) >> 3.
module rgb_scale (
  input  logic [3:0] i_c,
  input  logic [2:0] i_level,
  output logic [3:0] o_c
);

  logic [3:0] w_gain;
  logic [6:0] w_prod;

  // Level 0 gives gain 8 (unity after the shift), level 4 gives gain 4 (half).
  assign w_gain = 4'd8 - {1'b0, i_level};
  // 4x4-bit product fits in 7 bits (15 * 8 = 120).
  assign w_prod = {3'd0, i_c} * {3'd0, w_gain};
  assign o_c    = 4'(w_prod >> 3);

endmodule

// File: rtl/pause_dim_ctrl.sv
// Pause arbitration (user button, hiscore freeze, OSD) and a timed screen-dim
// stage that re-emits the video stream one pixel later.
module pause_dim_ctrl
  import pause_pkg::*;
#(
  parameter logic [31:0] DIM_DELAY  = DEF_DIM_DELAY,
  parameter logic [23:0] FADE_TICKS = DEF_FADE_TICKS,
  parameter logic [2:0]  MAX_LEVEL  = DEF_MAX_LEVEL
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    game_rst,
  input  logic                    pause_btn,
  input  logic                    hs_access,
  input  logic                    osd_status,
  input  logic                    osd_pause_en,
  input  logic                    ce_pix,
  pause_dim_ctrl_if.slave         vid_in,
  pause_dim_ctrl_if.master        vid_out,
  output logic                    pause,
  output logic                    user_paused,
  output logic [2:0]              dim_level
);

  // Terminal counts, widened to the timer width.
  localparam logic [31:0] L_DIM_LAST  = DIM_DELAY - 32'd1;
  localparam logic [31:0] L_FADE_LAST = {8'd0, FADE_TICKS} - 32'd1;

  // Button synchroniser, edge detector and user toggle.
  logic r_btn_s1;
  logic r_btn_s2;
  logic r_btn_d;
  logic r_user_paused;
  logic w_btn_rise;

  // Pause output register.
  logic r_pause;

  // Fade sequencer.
  fade_state_t r_state;
  fade_state_t w_state_nxt;
  logic [31:0] r_timer;
  logic [31:0] w_timer_nxt;
  logic [2:0]  r_dim;
  logic [2:0]  w_dim_nxt;

  // Video pipeline.
  rgb12_t r_rgb;
  rgb12_t w_rgb_scaled;
  logic   r_hblank;
  logic   r_vblank;
  logic   r_hs;
  logic   r_vs;

  assign w_btn_rise = r_btn_s2 & ~r_btn_d;

  // Two-flop synchroniser for the asynchronous pin, then a delayed copy for
  // rising-edge detection; a held button therefore toggles only once.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1      <= 1'b0;
      r_btn_s2      <= 1'b0;
      r_btn_d       <= 1'b0;
      r_user_paused <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so each flop
      // samples the pre-edge value of its neighbour regardless of order.
      r_btn_s1 <= pause_btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
      if (game_rst) begin
        r_user_paused <= 1'b0;
      end else if (w_btn_rise) begin
        r_user_paused <= ~r_user_paused;
      end
    end
  end

  // Merge every freeze source into the registered core PAUSE line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pause <= 1'b0;
    end else begin
      r_pause <= hs_access | r_user_paused | (osd_status & osd_pause_en);
    end
  end

  // Fade sequencer state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_dim   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_dim   <= w_dim_nxt;
    end
  end

  // Fade sequencer next state: only the user toggle drives the fade, and
  // leaving pause snaps straight back to full brightness.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dim_nxt   = r_dim;

    if (!r_user_paused) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_dim_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = '0;
          w_dim_nxt   = '0;
        end
        ST_WAIT: begin
          if (r_timer == L_DIM_LAST) begin
            w_timer_nxt = '0;
            w_dim_nxt   = 3'd1;
            w_state_nxt = (MAX_LEVEL <= 3'd1) ? ST_HOLD : ST_FADE;
          end else begin
            w_timer_nxt = r_timer + 32'd1;
          end
        end
        ST_FADE: begin
          if (r_timer == L_FADE_LAST) begin
            w_timer_nxt = '0;
            w_dim_nxt   = r_dim + 3'd1;
            if (r_dim + 3'd1 >= MAX_LEVEL) begin
              w_state_nxt = ST_HOLD;
            end
          end else begin
            w_timer_nxt = r_timer + 32'd1;
          end
        end
        ST_HOLD: begin
          // Final level reached; timer frozen until the user unpauses.
          w_dim_nxt = MAX_LEVEL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
          w_dim_nxt   = '0;
        end
      endcase
    end
  end

  // Per-channel dimmers, all fed the same level so a pixel is never torn.
  rgb_scale u_scale_r (
    .i_c     (vid_in.rgb.r),
    .i_level (r_dim),
    .o_c     (w_rgb_scaled.r)
  );

  rgb_scale u_scale_g (
    .i_c     (vid_in.rgb.g),
    .i_level (r_dim),
    .o_c     (w_rgb_scaled.g)
  );

  rgb_scale u_scale_b (
    .i_c     (vid_in.rgb.b),
    .i_level (r_dim),
    .o_c     (w_rgb_scaled.b)
  );

  // One-pixel video pipeline: colour and timing advance together on ce_pix,
  // with colour forced to black during blanking.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb    <= '0;
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
    end else if (ce_pix) begin
      r_rgb    <= (vid_in.hblank | vid_in.vblank) ? rgb12_t'('0) : w_rgb_scaled;
      r_hblank <= vid_in.hblank;
      r_vblank <= vid_in.vblank;
      r_hs     <= vid_in.hs;
      r_vs     <= vid_in.vs;
    end
  end

  assign pause          = r_pause;
  assign user_paused    = r_user_paused;
  assign dim_level      = r_dim;
  assign vid_out.rgb    = r_rgb;
  assign vid_out.hblank = r_hblank;
  assign vid_out.vblank = r_vblank;
  assign vid_out.hs     = r_hs;
  assign vid_out.vs     = r_vs;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Self-checking bench for pause_dim_ctrl: directed steps plus randomized video
// and button activity, compared against a behavioural model every cycle.
module tb_pause_dim_ctrl;
  import pause_pkg::*;

  localparam logic [31:0] DD = 32'd20;
  localparam logic [23:0] FT = 24'd5;
  localparam logic [2:0]  ML = 3'd4;

  logic       clk_sys      = 1'b0;
  logic       reset_n      = 1'b1;
  logic       game_rst     = 1'b0;
  logic       pause_btn    = 1'b0;
  logic       hs_access    = 1'b0;
  logic       osd_status   = 1'b0;
  logic       osd_pause_en = 1'b0;
  logic       ce_pix       = 1'b0;
  logic       pause;
  logic       user_paused;
  logic [2:0] dim_level;

  pause_dim_ctrl_if u_vin ();
  pause_dim_ctrl_if u_vout ();

  pause_dim_ctrl #(
    .DIM_DELAY  (DD),
    .FADE_TICKS (FT),
    .MAX_LEVEL  (ML)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .game_rst     (game_rst),
    .pause_btn    (pause_btn),
    .hs_access    (hs_access),
    .osd_status   (osd_status),
    .osd_pause_en (osd_pause_en),
    .ce_pix       (ce_pix),
    .vid_in       (u_vin),
    .vid_out      (u_vout),
    .pause        (pause),
    .user_paused  (user_paused),
    .dim_level    (dim_level)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fails = 0;
  bit rand_vid = 1'b0;
  bit rand_btn = 1'b0;

  // ---------------- behavioural model ----------------
  logic [2:0]  m_hist    = '0;   // pin samples at the last three edges
  logic        m_up      = 1'b0;
  logic        m_pause   = 1'b0;
  int          m_k       = 0;    // edges spent with the user toggle set
  logic [2:0]  m_dim     = '0;
  logic [11:0] m_rgb     = '0;
  logic        m_hb      = 1'b1;
  logic        m_vb      = 1'b1;
  logic        m_hs      = 1'b1;
  logic        m_vs      = 1'b1;
  logic        m_rise;
  logic        m_up_old;
  logic [2:0]  m_dim_old;

  // Dim level after k paused cycles: 0 for the first DD, then one step per FT.
  function automatic logic [2:0] dim_of(input int k);
    int lv;
    if (k <= int'(DD)) return 3'd0;
    lv = 1 + (k - int'(DD) - 1) / int'(FT);
    if (lv > int'(ML)) lv = int'(ML);
    return 3'(lv);
  endfunction

  function automatic logic [11:0] scale_px(input logic [11:0] px, input logic [2:0] d);
    logic [11:0] res;
    int v;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      v = (int'(px[c*4 +: 4]) * (8 - int'(d))) / 8;
      res[c*4 +: 4] = 4'(v);
    end
    return res;
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_hist  = '0;
      m_up    = 1'b0;
      m_pause = 1'b0;
      m_k     = 0;
      m_dim   = '0;
      m_rgb   = '0;
      m_hb    = 1'b1;
      m_vb    = 1'b1;
      m_hs    = 1'b1;
      m_vs    = 1'b1;
    end else begin
      m_up_old  = m_up;
      m_dim_old = m_dim;
      // The toggle lands on the third edge after the pin is first seen high.
      m_rise    = m_hist[1] & ~m_hist[2];
      m_hist    = {m_hist[1:0], pause_btn};
      m_up      = game_rst ? 1'b0 : (m_up_old ^ m_rise);
      m_pause   = hs_access | m_up_old | (osd_status & osd_pause_en);
      if (!m_up_old) m_k = 0;
      else if (m_k < 1_000_000) m_k = m_k + 1;
      m_dim     = m_up_old ? dim_of(m_k) : 3'd0;
      if (ce_pix) begin
        m_rgb = (u_vin.hblank | u_vin.vblank) ? 12'h000 : scale_px(u_vin.rgb, m_dim_old);
        m_hb  = u_vin.hblank;
        m_vb  = u_vin.vblank;
        m_hs  = u_vin.hs;
        m_vs  = u_vin.vs;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pause",       32'(pause),           32'(m_pause));
    check("user_paused", 32'(user_paused),     32'(m_up));
    check("dim_level",   32'(dim_level),       32'(m_dim));
    check("rgb_out",     32'(u_vout.rgb),      32'(m_rgb));
    check("hblank_out",  32'(u_vout.hblank),   32'(m_hb));
    check("vblank_out",  32'(u_vout.vblank),   32'(m_vb));
    check("hs_out",      32'(u_vout.hs),       32'(m_hs));
    check("vs_out",      32'(u_vout.vs),       32'(m_vs));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pause"},  32'(pause),          32'd0);
    check({tag, "_up"},     32'(user_paused),    32'd0);
    check({tag, "_dim"},    32'(dim_level),      32'd0);
    check({tag, "_rgb"},    32'(u_vout.rgb),     32'd0);
    check({tag, "_hblank"}, 32'(u_vout.hblank),  32'd1);
    check({tag, "_vblank"}, 32'(u_vout.vblank),  32'd1);
    check({tag, "_hs"},     32'(u_vout.hs),      32'd1);
    check({tag, "_vs"},     32'(u_vout.vs),      32'd1);
  endtask

  // Advance n cycles: check on each falling edge, then drive the next inputs.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      check_all();
      if (rand_vid) begin
        u_vin.rgb    = rgb12_t'(12'($urandom));
        u_vin.hblank = ($urandom_range(7) == 0);
        u_vin.vblank = ($urandom_range(15) == 0);
        u_vin.hs     = 1'($urandom);
        u_vin.vs     = 1'($urandom);
        ce_pix       = 1'($urandom);
      end
      if (rand_btn && $urandom_range(15) == 0) pause_btn = ~pause_btn;
    end
  endtask

  // Bounded wait for the DUT to reach a fade level.
  task automatic wait_dim(input logic [2:0] lv);
    int n;
    n = 0;
    while (dim_level !== lv && n < 400) begin
      run(1);
      n++;
    end
    check("wait_dim", 32'(dim_level), 32'(lv));
  endtask

  task automatic set_video(input logic [11:0] px, input logic blank);
    u_vin.rgb    = rgb12_t'(px);
    u_vin.hblank = blank;
    u_vin.vblank = blank;
    u_vin.hs     = 1'b0;
    u_vin.vs     = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_video(12'h000, 1'b0);

    // Reset applied with no clock edge yet: outputs at reset values.
    #1 reset_n = 1'b0;
    #2 check_reset_values("rst_async");
    #20 check_all();

    // Release reset with idle inputs and no ce_pix: nothing moves.
    @(negedge clk_sys);
    reset_n = 1'b1;
    run(6);
    check_reset_values("idle");

    // Full-white pixel passes through unchanged one ce_pix later.
    set_video(12'hFFF, 1'b0);
    ce_pix = 1'b1;
    run(1);
    check("pass_fff", 32'(u_vout.rgb), 32'h0FFF);
    ce_pix = 1'b0;
    run(3);
    ce_pix = 1'b1;
    run(2);

    // Button held: toggle lands on the third edge, pause one edge later.
    pause_btn = 1'b1;
    run(2);
    check("btn_lat2", 32'(user_paused), 32'd0);
    run(1);
    check("btn_lat3", 32'(user_paused), 32'd1);
    check("pause_lag", 32'(pause), 32'd0);
    run(1);
    check("pause_on", 32'(pause), 32'd1);
    run(96);
    check("btn_held_once", 32'(user_paused), 32'd1);
    check("dim_max", 32'(dim_level), 32'(ML));
    check("rgb_half", 32'(u_vout.rgb), 32'h0777);
    pause_btn = 1'b0;
    run(5);

    // Second press clears the toggle and the fade.
    pause_btn = 1'b1;
    run(3);
    check("unpause_up", 32'(user_paused), 32'd0);
    run(1);
    check("unpause_pause", 32'(pause), 32'd0);
    check("unpause_dim", 32'(dim_level), 32'd0);
    run(1);
    check("unpause_rgb", 32'(u_vout.rgb), 32'h0FFF);
    pause_btn = 1'b0;
    run(5);

    // Unpause mid-fade at level 3 with ce_pix held off.
    pause_btn = 1'b1;
    run(3);
    pause_btn = 1'b0;
    wait_dim(3'd3);
    run(1);
    ce_pix = 1'b0;
    pause_btn = 1'b1;
    run(3);
    check("mid_up", 32'(user_paused), 32'd0);
    run(1);
    check("mid_dim0", 32'(dim_level), 32'd0);
    check("mid_rgb_hold", 32'(u_vout.rgb), 32'h0999);
    ce_pix = 1'b1;
    run(1);
    check("mid_rgb_full", 32'(u_vout.rgb), 32'h0FFF);
    pause_btn = 1'b0;
    run(5);

    // Hiscore freeze holds pause but never starts the fade.
    rand_vid  = 1'b1;
    hs_access = 1'b1;
    run(1000);
    check("hs_pause", 32'(pause), 32'd1);
    check("hs_dim", 32'(dim_level), 32'd0);
    hs_access = 1'b0;
    run(2);
    check("hs_release", 32'(pause), 32'd0);

    // OSD pause only when enabled.
    osd_status = 1'b1;
    run(3);
    check("osd_dis", 32'(pause), 32'd0);
    osd_pause_en = 1'b1;
    run(2);
    check("osd_en", 32'(pause), 32'd1);
    osd_status = 1'b0;
    run(2);
    check("osd_off", 32'(pause), 32'd0);
    osd_pause_en = 1'b0;

    // game_rst coinciding with the toggle edge wins.
    pause_btn = 1'b1;
    run(2);
    game_rst = 1'b1;
    run(1);
    check("grst_prio", 32'(user_paused), 32'd0);
    game_rst = 1'b0;
    run(3);
    check("grst_noretrig", 32'(user_paused), 32'd0);
    pause_btn = 1'b0;
    run(3);

    // Random button activity alongside random video.
    rand_btn = 1'b1;
    run(600);
    rand_btn  = 1'b0;
    pause_btn = 1'b0;
    run(5);
    if (user_paused === 1'b1) begin
      pause_btn = 1'b1;
      run(4);
      pause_btn = 1'b0;
      run(4);
    end

    // Asynchronous reset in the middle of a fade.
    pause_btn = 1'b1;
    run(3);
    pause_btn = 1'b0;
    wait_dim(3'd2);
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_reset_values("rst_midfade");
    check_all();
    run(3);
    @(negedge clk_sys);
    reset_n = 1'b1;
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
